// File: rtl/aes_pkg.sv
// Shared constants and FSM encoding for the AES round controller.
package aes_pkg;

  localparam int NUM_ROUNDS = 10;
  localparam int KEY_W      = 128;
  localparam int BANK_W     = KEY_W * (NUM_ROUNDS + 1);
  localparam int RND_W      = 4;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_KSTART = 3'd1,
    ST_KWAIT  = 3'd2,
    ST_ROUND  = 3'd3,
    ST_OUT    = 3'd4
  } state_t;

endpackage

// File: rtl/aes_rkey_sel.sv
// Selects the 128-bit round key for a round index out of the expanded key bank.
module aes_rkey_sel
  import aes_pkg::*;
(
  input  logic [BANK_W-1:0] i_KeyBank,
  input  logic [RND_W-1:0]  i_RndIdx,
  output logic [KEY_W-1:0]  o_RoundKey
);

  // Round 0 sits in the most significant slice; out-of-range indices give zero.
  always_comb begin
    o_RoundKey = '0;
    for (int r = 0; r <= NUM_ROUNDS; r++) begin
      if (i_RndIdx == RND_W'(r)) begin
        o_RoundKey = i_KeyBank[BANK_W-1-KEY_W*r -: KEY_W];
      end
    end
  end

endmodule

// File: rtl/aes_round_ctrl.sv
// Sequences key expansion and the eleven AES rounds for one block request,
// caching the expanded key between requests that do not carry a new key.
module aes_round_ctrl
  import aes_pkg::*;
#(
  parameter int KE_TIMEOUT = 255
) (
  input  logic              i_Clk,
  input  logic              i_Rst,
  input  logic              i_Valid,
  output logic              o_Ready,
  input  logic              i_fNewKey,
  output logic              o_KeyStart,
  output logic              o_KeyIsFirst,
  input  logic              i_KeyDone,
  input  logic [BANK_W-1:0] i_KeyBank,
  output logic              o_RndEn,
  output logic [RND_W-1:0]  o_RndIdx,
  output logic              o_fInit,
  output logic              o_fFinal,
  output logic [KEY_W-1:0]  o_RoundKey,
  output logic              o_OutValid,
  input  logic              i_OutReady,
  output logic              o_fErr,
  output state_t            o_State
);

  // Handshakes: a request transfers on a cycle with i_Valid && o_Ready; a result
  // transfers on a cycle with o_OutValid && i_OutReady. Neither ready depends on valid.

  localparam logic [15:0] TMO_LAST = 16'(KE_TIMEOUT);
  localparam logic [RND_W-1:0] RND_LAST = RND_W'(NUM_ROUNDS);

  state_t           state, stateNxt;
  logic [RND_W-1:0] rndCnt, rndNxt;
  logic [15:0]      tmoCnt, tmoNxt;
  logic             cacheVld, cacheNxt;
  logic             errQ, errNxt;
  logic [KEY_W-1:0] selKey;

  always_ff @(posedge i_Clk or negedge i_Rst) begin
    if (!i_Rst) begin
      state    <= ST_IDLE;
      rndCnt   <= '0;
      tmoCnt   <= '0;
      cacheVld <= 1'b0;
      errQ     <= 1'b0;
    end else begin
      state    <= stateNxt;
      rndCnt   <= rndNxt;
      tmoCnt   <= tmoNxt;
      cacheVld <= cacheNxt;
      errQ     <= errNxt;
    end
  end

  always_comb begin
    stateNxt = state;
    rndNxt   = rndCnt;
    tmoNxt   = tmoCnt;
    cacheNxt = cacheVld;
    errNxt   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (i_Valid) begin
          if (i_fNewKey || !cacheVld) begin
            stateNxt = ST_KSTART;
          end else begin
            stateNxt = ST_ROUND;
            rndNxt   = '0;
          end
        end
      end
      ST_KSTART: begin
        tmoNxt   = '0;
        stateNxt = ST_KWAIT;
      end
      ST_KWAIT: begin
        if (i_KeyDone) begin
          cacheNxt = 1'b1;
          rndNxt   = '0;
          stateNxt = ST_ROUND;
        end else if (tmoCnt + 16'd1 == TMO_LAST) begin
          // Registered pulse lands KE_TIMEOUT+1 cycles after the start pulse.
          errNxt   = 1'b1;
          cacheNxt = 1'b0;
          stateNxt = ST_IDLE;
        end else begin
          tmoNxt = tmoCnt + 16'd1;
        end
      end
      ST_ROUND: begin
        if (rndCnt == RND_LAST) begin
          stateNxt = ST_OUT;
        end else begin
          rndNxt = rndCnt + 1'b1;
        end
      end
      ST_OUT: begin
        if (i_OutReady) begin
          stateNxt = ST_IDLE;
        end
      end
      default: stateNxt = ST_IDLE;
    endcase
    // A corrupted round counter recovers to IDLE from any state.
    if (rndCnt > RND_LAST) begin
      stateNxt = ST_IDLE;
      rndNxt   = '0;
    end
  end

  aes_rkey_sel u_rkey_sel (
    .i_KeyBank  (i_KeyBank),
    .i_RndIdx   (rndCnt),
    .o_RoundKey (selKey)
  );

  assign o_Ready      = (state == ST_IDLE);
  assign o_KeyStart   = (state == ST_KSTART);
  assign o_KeyIsFirst = o_KeyStart;
  assign o_RndEn      = (state == ST_ROUND);
  assign o_RndIdx     = rndCnt;
  assign o_fInit      = o_RndEn && (rndCnt == '0);
  assign o_fFinal     = o_RndEn && (rndCnt == RND_LAST);
  assign o_RoundKey   = o_RndEn ? selKey : '0;
  assign o_OutValid   = (state == ST_OUT);
  assign o_fErr       = errQ;
  assign o_State      = state;

endmodule
